// File: rtl/div_request_sequencer_if.sv
// Request/result handshake bundle for div_request_sequencer.
// slave: the sequencer side; master: the producer/consumer side.
interface div_request_sequencer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int TAG_WIDTH  = 4
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_numerator;
  logic [DATA_WIDTH-1:0] s_denominator;
  logic [TAG_WIDTH-1:0]  s_tag;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_quotient;
  logic [DATA_WIDTH-1:0] m_remainder;
  logic [TAG_WIDTH-1:0]  m_tag;
  logic [1:0]            m_error;

  modport slave (
    input  s_valid, s_numerator, s_denominator, s_tag, m_ready,
    output s_ready, m_valid, m_quotient, m_remainder, m_tag, m_error
  );

  modport master (
    output s_valid, s_numerator, s_denominator, s_tag, m_ready,
    input  s_ready, m_valid, m_quotient, m_remainder, m_tag, m_error
  );
endinterface

// File: rtl/div_request_sequencer.sv
// Queues tagged divide requests, issues them one at a time to the
// restoring divider, returns results with tag, div0 and timeout flags.
// Ports: aclk, reset (async high); bus (request/result handshake);
// div_* (divider side); fifo_level (entries currently queued).
module div_request_sequencer #(
  parameter int DATA_WIDTH     = 12,
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         aclk,
  input  logic                         reset,
  div_request_sequencer_if.slave       bus,
  output logic [DATA_WIDTH-1:0]        div_numerator,
  output logic [DATA_WIDTH-1:0]        div_denominator,
  output logic                         div_data_valid,
  input  logic [DATA_WIDTH-1:0]        div_quotient,
  input  logic [DATA_WIDTH-1:0]        div_remainder,
  input  logic                         div_data_ready,
  input  logic                         div_error_div0,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = TAG_WIDTH + 2 * DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t state, nxt;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         count;
  logic [EW-1:0]         head;
  logic                  full, push, pop;
  logic                  live;

  logic [TAG_WIDTH-1:0]  tag_q;
  logic [CW-1:0]         timer;
  logic                  timeout;

  logic                  cap;
  logic [DATA_WIDTH-1:0] nq, nr;
  logic [1:0]            ne;

  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_quot_q, m_rem_q;
  logic [TAG_WIDTH-1:0]  m_tag_q;
  logic [1:0]            m_err_q;

  // s_ready stays low while in reset and rises on the first edge after.
  assign full         = (count == LW'(FIFO_DEPTH));
  assign bus.s_ready  = live & ~full;
  assign push         = bus.s_valid & bus.s_ready;
  assign head         = mem[rd_ptr];
  assign fifo_level   = count;
  assign timeout      = (timer == CW'(TIMEOUT_CYCLES - 1));

  assign bus.m_valid     = m_valid_q;
  assign bus.m_quotient  = m_quot_q;
  assign bus.m_remainder = m_rem_q;
  assign bus.m_tag       = m_tag_q;
  assign bus.m_error     = m_err_q;

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {bus.s_tag, bus.s_denominator, bus.s_numerator};
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      live   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      live <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Responses only count in WAIT; div0 beats data_ready, and a real
  // response on the last counted cycle beats the timeout.
  always_comb begin
    nxt = state;
    pop = 1'b0;
    cap = 1'b0;
    nq  = '0;
    nr  = '0;
    ne  = 2'b00;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          nxt = ISSUE;
        end
      end
      ISSUE: nxt = WAIT;
      WAIT: begin
        if (div_error_div0) begin
          cap = 1'b1;
          nq  = '1;
          nr  = div_numerator;
          ne  = 2'b01;
        end else if (div_data_ready) begin
          cap = 1'b1;
          nq  = div_quotient;
          nr  = div_remainder;
        end else if (timeout) begin
          cap = 1'b1;
          ne  = 2'b10;
        end
        if (cap) nxt = HOLD;
      end
      HOLD: begin
        if (bus.m_ready) nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      div_numerator   <= '0;
      div_denominator <= '0;
      div_data_valid  <= 1'b0;
      tag_q           <= '0;
      timer           <= '0;
    end else begin
      div_data_valid <= pop;
      if (pop) begin
        div_numerator   <= head[DATA_WIDTH-1:0];
        div_denominator <= head[2*DATA_WIDTH-1:DATA_WIDTH];
        tag_q           <= head[EW-1:2*DATA_WIDTH];
      end
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_quot_q  <= '0;
      m_rem_q   <= '0;
      m_tag_q   <= '0;
      m_err_q   <= 2'b00;
    end else if (cap) begin
      m_valid_q <= 1'b1;
      m_quot_q  <= nq;
      m_rem_q   <= nr;
      m_tag_q   <= tag_q;
      m_err_q   <= ne;
    end else if (state == HOLD && bus.m_ready) begin
      m_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_div_request_sequencer.sv
// Directed bench for div_request_sequencer with a behavioural divider
// that answers 2*W+2 cycles after data_valid.
module tb_div_request_sequencer;
  localparam int W = 12;

  logic aclk = 1'b0;
  logic reset = 1'b0;
  always #5 aclk = ~aclk;

  div_request_sequencer_if #(.DATA_WIDTH(W), .TAG_WIDTH(4)) bus ();

  logic [W-1:0] div_numerator, div_denominator;
  logic [W-1:0] div_quotient = '0;
  logic [W-1:0] div_remainder = '0;
  logic         div_data_valid;
  logic         div_data_ready = 1'b0;
  logic         div_error_div0 = 1'b0;
  logic [2:0]   fifo_level;

  div_request_sequencer #(
    .DATA_WIDTH(W), .FIFO_DEPTH(4), .TAG_WIDTH(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .aclk            (aclk),
    .reset           (reset),
    .bus             (bus),
    .div_numerator   (div_numerator),
    .div_denominator (div_denominator),
    .div_data_valid  (div_data_valid),
    .div_quotient    (div_quotient),
    .div_remainder   (div_remainder),
    .div_data_ready  (div_data_ready),
    .div_error_div0  (div_error_div0),
    .fifo_level      (fifo_level)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // divider model
  bit         respond_en = 1'b1;
  int         cnt = 0;
  int         late_req = 0;
  int         late_done = 0;
  logic [W-1:0] ln, ld;

  always @(negedge aclk) begin
    div_data_ready = 1'b0;
    div_error_div0 = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && respond_en) begin
        if (ld == 0) div_error_div0 = 1'b1;
        else begin
          div_quotient   = ln / ld;
          div_remainder  = ln % ld;
          div_data_ready = 1'b1;
        end
      end
    end
    if (late_req != late_done) begin
      late_done      = late_req;
      div_quotient   = 12'h5A5;
      div_remainder  = 12'h0A5;
      div_data_ready = 1'b1;
    end
    if (div_data_valid) begin
      cnt = 2 * W + 2;
      ln  = div_numerator;
      ld  = div_denominator;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push(input int n, input int d, input int t);
    bus.s_valid       = 1'b1;
    bus.s_numerator   = W'(n);
    bus.s_denominator = W'(d);
    bus.s_tag         = 4'(t);
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_mv(input int max, output int k);
    k = 0;
    while (!bus.m_valid && k < max) begin
      tick();
      k++;
    end
    chk("m_valid_seen", bus.m_valid, 1);
  endtask

  task automatic chk_res(input string tag, input int t, input int q,
                         input int r, input int e);
    chk({tag, "_tag"}, bus.m_tag, t);
    chk({tag, "_q"}, bus.m_quotient, q);
    chk({tag, "_r"}, bus.m_remainder, r);
    chk({tag, "_err"}, bus.m_error, e);
  endtask

  int k;
  int seen;
  int tg [4] = '{6, 7, 8, 9};
  int nm [4] = '{200, 4095, 1, 144};
  int dn [4] = '{10, 16, 3, 12};
  int qq [4] = '{20, 255, 0, 12};
  int rr [4] = '{0, 15, 1, 0};

  initial begin
    bus.s_valid       = 1'b0;
    bus.s_numerator   = '0;
    bus.s_denominator = '0;
    bus.s_tag         = '0;
    bus.m_ready       = 1'b0;

    // reset state
    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_dv", div_data_valid, 0);
    chk("rst_level", fifo_level, 0);
    reset = 1'b0;
    tick();
    chk("rst_s_ready_up", bus.s_ready, 1);

    // 1: basic request, latency
    bus.m_ready = 1'b1;
    push(100, 7, 3);
    chk("t1_dv_early", div_data_valid, 0);
    tick();
    chk("t1_dv", div_data_valid, 1);
    chk("t1_num", div_numerator, 100);
    chk("t1_den", div_denominator, 7);
    tick();
    chk("t1_dv_one", div_data_valid, 0);
    wait_mv(100, k);
    chk("t1_latency", 3 + k, 29);
    chk_res("t1", 3, 14, 2, 0);
    tick();
    chk("t1_m_valid_drop", bus.m_valid, 0);

    // 2: divide by zero
    push(55, 0, 5);
    wait_mv(100, k);
    chk_res("t2", 5, 12'hFFF, 55, 1);
    tick();
    chk("t2_m_valid_drop", bus.m_valid, 0);

    // 3: fill the FIFO behind a held result
    bus.m_ready = 1'b0;
    push(9, 2, 1);
    wait_mv(100, k);
    for (int i = 0; i < 5; i++) begin
      bus.s_valid       = 1'b1;
      bus.s_numerator   = W'(i < 4 ? nm[i] : 77);
      bus.s_denominator = W'(i < 4 ? dn[i] : 7);
      bus.s_tag         = 4'(i < 4 ? tg[i] : 10);
      chk("t3_s_ready", bus.s_ready, (i < 4) ? 1 : 0);
      tick();
    end
    bus.s_valid = 1'b0;
    chk("t3_level_full", fifo_level, 4);
    chk_res("t3_p0", 1, 4, 1, 0);
    bus.m_ready = 1'b1;
    tick();
    chk("t3_idle_m_valid", bus.m_valid, 0);
    chk("t3_idle_level", fifo_level, 4);
    tick();
    chk("t3_pop_level", fifo_level, 3);
    for (int i = 0; i < 4; i++) begin
      wait_mv(100, k);
      chk_res($sformatf("t3_r%0d", i), tg[i], qq[i], rr[i], 0);
      tick();
    end
    chk("t3_level_end", fifo_level, 0);
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.m_valid) seen++;
    end
    chk("t3_no_extra", seen, 0);

    // 4: divider never answers
    respond_en  = 1'b0;
    bus.m_ready = 1'b0;
    push(20, 4, 2);
    wait_mv(200, k);
    chk("t4_latency", 1 + k, 67);
    chk_res("t4", 2, 0, 0, 2);
    late_req++;
    tick();
    tick();
    chk("t4_frozen_q", bus.m_quotient, 0);
    chk("t4_frozen_err", bus.m_error, 2);
    chk("t4_frozen_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    tick();
    chk("t4_m_valid_drop", bus.m_valid, 0);
    late_req++;
    seen = 0;
    repeat (5) begin
      tick();
      if (bus.m_valid || div_data_valid) seen++;
    end
    chk("t4_late_ignored", seen, 0);
    respond_en = 1'b1;

    // 5: reset during WAIT with two queued
    bus.m_ready = 1'b0;
    push(30, 3, 4);
    push(31, 3, 5);
    push(32, 3, 6);
    repeat (5) tick();
    chk("t5_level_pre", fifo_level, 2);
    reset = 1'b1;
    #1;
    chk("t5_level", fifo_level, 0);
    chk("t5_s_ready", bus.s_ready, 0);
    chk("t5_num", div_numerator, 0);
    chk("t5_m_err", bus.m_error, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("t5_s_ready_up", bus.s_ready, 1);
    seen = 0;
    repeat (60) begin
      tick();
      if (bus.m_valid || div_data_valid) seen++;
    end
    chk("t5_no_result", seen, 0);

    // 6: push on HOLD exit, then push+pop at level 2
    push(50, 5, 11);
    wait_mv(100, k);
    chk_res("t6_a", 11, 10, 0, 0);
    push(81, 9, 12);
    chk("t6_level1", fifo_level, 1);
    bus.m_ready       = 1'b1;
    bus.s_valid       = 1'b1;
    bus.s_numerator   = W'(100);
    bus.s_denominator = W'(33);
    bus.s_tag         = 4'(13);
    tick();
    bus.m_ready = 1'b0;
    chk("t6_exit_valid", bus.m_valid, 0);
    chk("t6_level2", fifo_level, 2);
    bus.s_numerator   = W'(7);
    bus.s_denominator = W'(7);
    bus.s_tag         = 4'(14);
    tick();
    bus.s_valid = 1'b0;
    chk("t6_level_same", fifo_level, 2);
    chk("t6_issue_num", div_numerator, 81);
    bus.m_ready = 1'b1;
    wait_mv(100, k);
    chk_res("t6_b", 12, 9, 0, 0);
    tick();
    wait_mv(100, k);
    chk_res("t6_c", 13, 3, 1, 0);
    tick();
    wait_mv(100, k);
    chk_res("t6_d", 14, 1, 0, 0);
    tick();
    chk("t6_level_end", fifo_level, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
